// File: rtl/rr_arbiter_lock.sv
// rr_arbiter_lock
//
// Round-robin arbiter for N requesters in front of a shared resource. It issues a
// registered one-hot grant and completes each granted beat with a valid/ready
// handshake. After every release the search starts at the requester just above the
// one that released, so grants rotate and can follow each other with no idle cycle.
// The granted requester can keep the grant across consecutive transfers by holding
// its lock bit. At most MAX_HOLD transfers are kept this way, so no requester can
// starve the others.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   req[N]       level-sensitive request per requester
//   lock[N]      keep the grant after this transfer (looked at only for the granted
//                requester, and only on a transfer)
//   ready        downstream accepts the current granted beat
//   grant[N]     registered one-hot grant, all-zero when idle
//   grant_id     binary index of the granted requester, valid while grant_valid=1
//   grant_valid  registered, equal to |grant

module rr_arbiter_lock #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    input  logic           ready,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] grant_id,
    output logic           grant_valid
);

    // Wide enough to hold MAX_HOLD-1 without wrapping.
    localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

    // After reset the pointer sits on the top requester, so requester 0 wins first.
    localparam logic [IDW-1:0] LastPtrInit = IDW'(N - 1);

    typedef enum logic {StIdle, StGranted} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_ptr_q, last_ptr_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

    logic [IDW-1:0] arb_ptr;
    logic [IDW-1:0] win_id;
    logic           win_found;
    logic [N-1:0]   win_onehot;

    logic xfer;
    logic cur_req;
    logic cur_lock;
    logic hold_ok;
    logic keep;
    logic do_release;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // In IDLE the search starts from the stored pointer. In GRANTED the only time
    // the result is used is a release, and then the pointer moves to the current
    // holder in the same cycle. Using id_q directly gives the back-to-back grant
    // without waiting for last_ptr to update.
    always_comb begin
        arb_ptr   = (state_q == StGranted) ? id_q : last_ptr_q;
        win_found = 1'b0;
        win_id    = '0;
        // First pass: requesters strictly above the pointer.
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && req[i] && (i > 32'(arb_ptr))) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
        // Wrap-around pass. It also includes the pointer itself, so a lone
        // persistent requester is granted again.
        for (int unsigned i = 0; i < N; i++) begin
            if (!win_found && req[i]) begin
                win_found = 1'b1;
                win_id    = IDW'(i);
            end
        end
        win_onehot = {{(N-1){1'b0}}, 1'b1} << win_id;
    end

    // ------------------------------------------------------------------
    // Transfer / hold decode
    // ------------------------------------------------------------------
    always_comb begin
        xfer     = (state_q == StGranted) && ready;
        cur_req  = req[id_q];
        cur_lock = lock[id_q];
        hold_ok  = 32'(hold_cnt_q) < (MAX_HOLD - 1);
        keep     = xfer && cur_lock && cur_req && hold_ok;
        // Release on any transfer that is not kept, or when the holder drops
        // its request while stalled.
        do_release = (state_q == StGranted) && !keep && (ready || !cur_req);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            id_q       <= '0;
            last_ptr_q <= LastPtrInit;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            id_q       <= id_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        id_d       = id_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d    = StGranted;
                    grant_d    = win_onehot;
                    id_d       = win_id;
                    hold_cnt_d = '0;
                end
            end

            StGranted: begin
                if (keep) begin
                    // Grant and pointer stay put. Stalled cycles never get here.
                    hold_cnt_d = hold_cnt_q + HCW'(1);
                end else if (do_release) begin
                    last_ptr_d = id_q;
                    hold_cnt_d = '0;
                    if (win_found) begin
                        grant_d = win_onehot;
                        id_d    = win_id;
                    end else begin
                        state_d = StIdle;
                        grant_d = '0;
                        id_d    = '0;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                grant_d = '0;
                id_d    = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (all straight from registers)
    // ------------------------------------------------------------------
    always_comb begin
        grant       = grant_q;
        grant_id    = id_q;
        grant_valid = (state_q == StGranted);
    end

`ifndef SYNTHESIS
    // Inputs must be X-free once out of reset.
    inputs_known: assert property (@(posedge clk) disable iff (rst)
        !$isunknown({req, lock, ready}));

    grant_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant_q));

    valid_matches_grant: assert property (@(posedge clk) disable iff (rst)
        ((state_q == StGranted) == (|grant_q)));
`endif

endmodule

// File: tb/tb_rr_arbiter_lock.sv
module tb_rr_arbiter_lock;

    localparam int N   = 4;
    localparam int MH  = 4;
    localparam int IDW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic           ready;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           grant_valid;

    int checks = 0;
    int errors = 0;

    // Reference model: who holds the grant, where the rotation resumes, and how
    // many transfers the holder has completed in its current tenure.
    bit m_valid;
    int m_id;
    int m_last;
    int m_xfers;

    always #5 clk = ~clk;

    rr_arbiter_lock #(
        .N        (N),
        .MAX_HOLD (MH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .lock        (lock),
        .ready       (ready),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk round the ring starting just after 'from'. The last candidate is 'from'
    // itself.
    function automatic int rot_pick(input logic [N-1:0] r, input int from);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (from + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = 0;
        m_last  = N - 1;
        m_xfers = 0;
    endtask

    task automatic model_update();
        int w;
        if (!m_valid) begin
            w = rot_pick(req, m_last);
            if (w >= 0) begin
                m_valid = 1'b1;
                m_id    = w;
                m_xfers = 0;
            end
        end else if (ready && lock[m_id] && req[m_id] && (m_xfers + 1 < MH)) begin
            m_xfers++;
        end else if (ready || !req[m_id]) begin
            m_last  = m_id;
            m_xfers = 0;
            w = rot_pick(req, m_id);
            if (w >= 0) m_id = w;
            else        m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] e;
        e = '0;
        if (m_valid) e[m_id] = 1'b1;
        check("grant", grant, e);
        check("grant_valid", grant_valid, m_valid);
        if (m_valid) check("grant_id", grant_id, m_id);
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_update();
        #1;
        check_outputs();
    endtask

    // Bounded wait for a given requester to hold the grant.
    task automatic wait_id(input int id, input string tag);
        for (int i = 0; i < 12; i++) begin
            if (grant_valid && grant_id == IDW'(id)) break;
            step();
        end
        check(tag, {grant_valid, grant_id}, {1'b1, IDW'(id)});
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        req   = '0;
        lock  = '0;
        ready = 1'b0;
        model_reset();
        #12;
        check("reset_grant", grant, 0);
        check("reset_valid", grant_valid, 0);
        check("reset_id", grant_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full request, no lock: 0,1,2,3,... one per cycle.
        req   = 4'b1111;
        ready = 1'b1;
        step();
        check("first_grant_id", grant_id, 0);
        repeat (9) step();

        // Lone requester is granted again every cycle.
        req = 4'b0100;
        repeat (8) step();
        check("single_req", grant, 4'b0100);

        // Lock burst by requester 1 lasts exactly MH transfers.
        req  = 4'b1111;
        lock = 4'b0010;
        wait_id(1, "reach_id1");
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!(grant_valid && grant_id == IDW'(1))) break;
            cnt++;
            step();
        end
        check("lock_hold_len", cnt, MH);
        check("after_lock_id", grant_id, 2);

        // Same burst with stalls mixed in: stalls do not count toward the limit.
        wait_id(1, "reach_id1_again");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!(grant_valid && grant_id == IDW'(1))) break;
            ready = (i % 3 != 1);
            if (ready) cnt++;
            step();
        end
        check("lock_hold_stall", cnt, MH);
        ready = 1'b1;
        lock  = '0;

        // Long stall on id 3, then release wraps to 0.
        req = 4'b1000;
        wait_id(3, "reach_id3");
        req   = 4'b1111;
        ready = 1'b0;
        repeat (10) step();
        check("stall_hold", grant, 4'b1000);
        ready = 1'b1;
        step();
        check("after_stall_id", grant_id, 0);

        // Abandon while stalled: moves to the next requester above.
        req = 4'b0100;
        wait_id(2, "reach_id2");
        ready = 1'b0;
        req   = 4'b1000;
        step();
        check("abandon_next", grant, 4'b1000);
        // Abandon with nothing above: wraps to the lowest requester.
        ready = 1'b1;
        req   = 4'b0100;
        wait_id(2, "reach_id2_again");
        ready = 1'b0;
        req   = 4'b0011;
        step();
        check("abandon_wrap", grant_id, 0);

        // Reset in the middle of a locked burst.
        ready = 1'b1;
        req   = 4'b0010;
        lock  = 4'b0010;
        wait_id(1, "reach_id1_burst");
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_valid", grant_valid, 0);
        model_reset();
        req  = 4'b0011;
        lock = '0;
        step();
        rst = 1'b0;
        step();
        check("post_reset_id", grant_id, 0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            req   = N'($urandom);
            lock  = N'($urandom) | N'($urandom);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_lock.md
Name: rr_arbiter_lock

Overview:
- Parametrised round-robin arbiter with N requesters, a registered one-hot grant and a downstream valid/ready handshake.
- Sits in front of a shared resource such as a bus port or memory bank.
- Adds features over the fixed 4-way mask arbiter:
  - any requester count;
  - back-to-back grants with no idle cycle;
  - per-requester lock for multi-beat bursts, bounded by a hold limit so no requester can starve the others.

Parameters:
- N, 4, number of requesters (>=2).
- MAX_HOLD, 16, maximum consecutive transfers one requester may keep the grant via lock (>=1).
- IDW, $clog2(N), width of grant_id (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N  request per requester; level-sensitive.
- lock  in  N  per-requester "keep grant after this transfer" request; sampled only on transfer.
- ready  in  1  downstream accepts the current granted beat.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_id  out  IDW  binary index of the granted requester; valid only when grant_valid=1.
- grant_valid  out  1  equals |grant, registered.

Behaviour:
- Reset (async, immediate), all registers go to these values:
  - grant=0, grant_id=0, grant_valid=0, hold_cnt=0;
  - last_ptr=N-1, so requester 0 has highest priority after reset.
- Transfer: a transfer occurs in any cycle with grant_valid && ready.
- Arbitration function (combinational, computed from current req and last_ptr):
  - masked = req & bits strictly above last_ptr;
  - winner = lowest set bit of masked if masked!=0, else lowest set bit of req;
  - no winner if req=0.
- States:
  - IDLE (grant_valid=0);
  - GRANTED (grant_valid=1).
- IDLE:
  - if winner exists: next edge grant=onehot(winner), grant_id=winner, hold_cnt=0, go to GRANTED;
  - else stay in IDLE.
- GRANTED, transfer, keep case: lock[id] && req[id] && hold_cnt<MAX_HOLD-1:
  - grant unchanged, hold_cnt+1;
  - last_ptr unchanged.
- GRANTED, transfer, release case (all other transfers):
  - last_ptr<=id, hold_cnt<=0;
  - next grant = arbitration result computed with last_ptr=id in the same cycle. This gives back-to-back grants with no bubble.
  - If no winner, go to IDLE.
- GRANTED, no transfer, req[id]=1: grant held indefinitely. Ready stall does not count toward hold_cnt.
- GRANTED, no transfer, req[id]=0 (abandon):
  - release as above: last_ptr<=id, re-arbitrate;
  - the abandoned requester is excluded only by normal rotation.
- Grant changes only at clock edges. Grant is always one-hot or zero, never multi-hot.
- A single persistent requester with no lock is re-granted every cycle: unmasked fallback includes the requester itself.
- hold_cnt width is $clog2(MAX_HOLD)+1 and it never wraps. MAX_HOLD=1 disables lock.
- Fairness bound: with all N requesting and locking, each requester waits at most (N-1)*MAX_HOLD transfers.
- Reset asserted mid-burst: grant drops to 0 immediately. After release, priority restarts from requester 0.
- lock of non-granted requesters is ignored. req/lock X-free after reset is required (assert in sim).

Test Plan:
- Reset then req=4'b1111, lock=0, ready=1 held -> grant_id sequence 0,1,2,3,0,..., one per cycle, no gaps; first grant one cycle after req.
- req=4'b0100 only, ready=1 -> grant=4'b0100 every cycle continuously; grant_valid never drops.
- req=4'b1111, lock[1]=1, MAX_HOLD=4, ready=1 -> requester 1 holds exactly 4 transfers, then grant moves to 2.
- Granted id=3, ready=0 for 10 cycles -> grant stays 4'b1000 and hold_cnt unchanged. Then ready=1 with lock=0 -> next grant id=0 when req[0]=1.
- Granted id=2, req[2] drops while ready=0 -> next edge grant moves to id=3 if req[3]=1, else wraps to the lowest requester.
- Assert rst during a locked burst of id=1 -> grant=0 and grant_valid=0 asynchronously. After deassert with req=4'b0011 -> first grant id=0.
